// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter that funnels NUM_REQ word sources into one shared FIFO.
// Grant, write strobe, write data and ready are all combinational from the inputs and the
// round-robin pointer. Reset is synchronous and active-high.
// Optional feature: define ARB_BURST_EN to let one winner keep the grant for up to BURST_LEN
// consecutive words (IDLE/BURST FSM with owner register and burst counter).
module fifo_write_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic                          grant_valid,
    output logic [ID_WIDTH-1:0]           grant_id
);

    // Elaboration-time parameter sanity checks
    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
        $error("fifo_write_arbiter: NUM_REQ must be in 2..16");
    end
    if (BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_burst_len
        $error("fifo_write_arbiter: BURST_LEN must be in 1..255");
    end

    logic [ID_WIDTH-1:0]   r_rr_ptr;
    logic [ID_WIDTH-1:0]   w_rr_ptr_next;
    logic                  w_rr_hit;
    logic [ID_WIDTH-1:0]   w_rr_id;
    logic                  w_grant_valid;
    logic [ID_WIDTH-1:0]   w_grant_id;
    logic [ID_WIDTH-1:0]   w_id_plus1;
    logic                  w_xfer;
    logic [DATA_WIDTH-1:0] w_grant_data;

`ifdef ARB_BURST_EN
    typedef enum logic {StIdle, StBurst} state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [ID_WIDTH-1:0] r_owner;
    logic [ID_WIDTH-1:0] w_owner_next;
    logic [7:0]          r_count;
    logic [7:0]          w_count_next;
`endif

    // Round-robin search: first valid requester at or after r_rr_ptr, wrapping around
    always_comb begin
        int unsigned idx;
        w_rr_hit = 1'b0;
        w_rr_id  = '0;
        idx      = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_rr_hit && req_valid[idx]) begin
                w_rr_hit = 1'b1;
                w_rr_id  = ID_WIDTH'(idx);
            end
        end
    end

    // Grant selection; reset masks the grant so nothing is written during reset
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_id    = '0;
        if (!rst) begin
`ifdef ARB_BURST_EN
            // A burst owner keeps the grant even if its valid has just dropped
            if (r_state == StBurst) begin
                w_grant_valid = 1'b1;
                w_grant_id    = r_owner;
            end else
`endif
            if (w_rr_hit) begin
                w_grant_valid = 1'b1;
                w_grant_id    = w_rr_id;
            end
        end
    end

    // Transfer qualification and write-side outputs
    always_comb begin
        w_xfer       = w_grant_valid & req_valid[w_grant_id] & ~fifo_full;
        w_grant_data = req_data[32'(w_grant_id)*DATA_WIDTH +: DATA_WIDTH];
        w_id_plus1   = (32'(w_grant_id) == NUM_REQ - 1) ? '0 : w_grant_id + 1'b1;
        req_ready    = '0;
        if (w_xfer) begin
            req_ready[w_grant_id] = 1'b1;
        end
        fifo_wr_en   = w_xfer;
        fifo_data_in = w_grant_valid ? w_grant_data : '0;
        grant_valid  = w_grant_valid;
        grant_id     = w_grant_id;
    end

`ifdef ARB_BURST_EN
    // Burst FSM next state: owner holds the grant until BURST_LEN words or its valid drops
    always_comb begin
        w_state_next  = r_state;
        w_owner_next  = r_owner;
        w_count_next  = r_count;
        w_rr_ptr_next = r_rr_ptr;
        unique case (r_state)
            StIdle: begin
                if (w_xfer) begin
                    if (BURST_LEN <= 1) begin
                        w_rr_ptr_next = w_id_plus1;
                    end else begin
                        w_state_next = StBurst;
                        w_owner_next = w_grant_id;
                        w_count_next = 8'd1;
                    end
                end
            end
            StBurst: begin
                // A full FIFO freezes the burst entirely
                if (!fifo_full) begin
                    if (!req_valid[r_owner]) begin
                        w_state_next  = StIdle;
                        w_count_next  = 8'd0;
                        w_rr_ptr_next = w_id_plus1;
                    end else if (32'(r_count) + 1 >= BURST_LEN) begin
                        w_state_next  = StIdle;
                        w_count_next  = 8'd0;
                        w_rr_ptr_next = w_id_plus1;
                    end else begin
                        w_count_next = r_count + 8'd1;
                    end
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Burst FSM state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_owner <= '0;
            r_count <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_owner <= w_owner_next;
            r_count <= w_count_next;
        end
    end
`else
    // Per-word arbitration: pointer moves past the winner after every accepted word
    always_comb begin
        w_rr_ptr_next = r_rr_ptr;
        if (w_xfer) begin
            w_rr_ptr_next = w_id_plus1;
        end
    end
`endif

    // Round-robin pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else begin
            r_rr_ptr <= w_rr_ptr_next;
        end
    end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the width of one data word per requester.
REQ-002 SHALL have parameter NUM_REQ, default 4, the number of requesters (legal range 2..16).
REQ-003 SHALL have parameter BURST_LEN, default 4, the maximum consecutive writes per grant in burst mode (range 1..255).
REQ-004 SHALL have parameter ID_WIDTH, default $clog2(NUM_REQ), the width of grant_id.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port req_valid, input, NUM_REQ bits: bit i means requester i holds a word.
REQ-008 SHALL have port req_data, input, NUM_REQ*DATA_WIDTH bits: requester i's word is at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port req_ready, output, NUM_REQ bits: bit i high means requester i's word is accepted this cycle.
REQ-010 SHALL have port fifo_full, input, 1 bit: the full flag of the downstream shared FIFO.
REQ-011 SHALL have port fifo_wr_en, output, 1 bit: the FIFO write strobe.
REQ-012 SHALL have port fifo_data_in, output, DATA_WIDTH bits: the FIFO write data.
REQ-013 SHALL have port grant_valid, output, 1 bit: a requester is granted this cycle.
REQ-014 SHALL have port grant_id, output, ID_WIDTH bits: the index of the granted requester.

Function
REQ-015 SHALL select the winner each cycle combinationally by round-robin: the lowest-indexed valid requester at or after rr_ptr, wrapping from NUM_REQ-1 to 0.
REQ-016 SHALL drive grant_valid = |req_valid (or burst owner held), and grant_id = winner index; grant_id = 0 when grant_valid = 0.
REQ-017 SHALL define transfer = grant_valid & req_valid[grant_id] & !fifo_full.
REQ-018 SHALL drive fifo_wr_en = transfer, combinationally, with zero-cycle latency.
REQ-019 SHALL drive fifo_data_in = the granted requester's slice when grant_valid = 1, else 0.
REQ-020 SHALL assert req_ready[i] only when i == grant_id and transfer = 1; all other bits are 0, so req_ready is one-hot or zero.
REQ-021 SHALL, on a transfer (non-burst mode), set rr_ptr <= grant_id+1 modulo NUM_REQ at the next edge.
REQ-022 SHALL, when no transfer occurs, leave rr_ptr unchanged.
REQ-023 SHALL, while fifo_full = 1, hold fifo_wr_en = 0 and req_ready = 0; no word is dropped or duplicated.
REQ-024 SHALL make fifo_wr_en independent of any read activity on the FIFO; a same-cycle FIFO read does not clear fifo_full here.
REQ-025 SHALL require each requester to hold req_valid and its data stable until it receives req_ready; the bench checks this as a protocol assertion.
REQ-026 SHALL guarantee that a continuously valid requester is granted within NUM_REQ transfers (NUM_REQ*BURST_LEN transfers in burst mode).

Reset
REQ-027 SHALL, on rst = 1 at a clock edge, set rr_ptr = 0, the FSM to IDLE and the burst counter to 0.
REQ-028 SHALL hold the outputs during and right after reset to fifo_wr_en = 0, req_ready = 0, grant_valid = 0, grant_id = 0 and fifo_data_in = 0 while req_valid = 0.
REQ-029 SHALL make rst take priority over any transfer in the same cycle, discard a burst in progress, and not write the FIFO in that cycle.

Configuration
REQ-030 SHALL, when macro ARB_BURST_EN is defined, add an FSM with states IDLE and BURST, an owner register and a burst counter.
- IDLE -> BURST on a transfer: owner = winner, count = 1.
- In BURST, the grant is fixed to owner; each transfer increments count.
- BURST -> IDLE when count reaches BURST_LEN on a transfer, or when req_valid[owner] = 0; then rr_ptr = owner+1.
- fifo_full stalls BURST with no state change.
REQ-031 SHALL, when ARB_BURST_EN is undefined, contain no FSM, owner register or counter, and arbitrate per word as in REQ-021.

Verification
REQ-032 SHALL pass this scenario: reset, then req_valid = 4'b1111 with fifo_full = 0 for 8 cycles, giving grant order 0,1,2,3,0,1,2,3 with fifo_wr_en = 1 every cycle.
REQ-033 SHALL pass this scenario: only req 2 valid, with data 0xA5, giving a write of 0xA5 in the same cycle, req_ready = 4'b0100, and rr_ptr = 3 next.
REQ-034 SHALL pass this scenario: fifo_full = 1 for 3 cycles with req 1 valid, giving fifo_wr_en = 0 and req_ready = 0 for those cycles, then one write of req 1's word when full drops.
REQ-035 SHALL pass this scenario: rr_ptr = 3 with only req 0 valid, giving grant_id = 0 (wrap) and rr_ptr = 1 next.
REQ-036 SHALL pass this scenario: with ARB_BURST_EN, BURST_LEN = 4 and all valid, giving grant order 0,0,0,0,1,1,1,1; if req 0 drops after 2 words, the grant moves to req 1 on the next cycle.
REQ-037 SHALL pass this scenario: rst asserted mid-burst after 2 words, giving no write that cycle, grant_valid = 0, and restart from req 0.
